// File: rtl/eq2_resp_checker.sv
// Response analyzer for the eq2 comparator test path: accepts operand pairs over
// valid/ready, samples aeqb after a settle window and accumulates pass/fail statistics.
module eq2_resp_checker #(
    parameter int W      = 2,
    parameter int SETTLE = 4,
    parameter int NVEC   = 7,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             aeqb,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [CNT_W-1:0] fail_idx,
    output logic [W-1:0]     fail_a,
    output logic [W-1:0]     fail_b
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NVEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t             state_r;
    logic [SET_W-1:0]   settle_cnt_r;
    logic [CNT_W-1:0]   vec_idx_r;
    logic [CNT_W-1:0]   pass_cnt_r;
    logic [CNT_W-1:0]   fail_cnt_r;
    logic [CNT_W-1:0]   fail_idx_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       fail_a_r;
    logic [W-1:0]       fail_b_r;
    logic               exp_r;
    logic               err_r;
    logic               busy_r;
    logic               done_r;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == CNT_MAX) begin
            sat_inc = cnt;
        end else begin
            sat_inc = cnt + 1'b1;
        end
    endfunction

    // Run-control FSM with statistics and first-failure capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= {SET_W{1'b0}};
            vec_idx_r    <= {CNT_W{1'b0}};
            pass_cnt_r   <= {CNT_W{1'b0}};
            fail_cnt_r   <= {CNT_W{1'b0}};
            fail_idx_r   <= {CNT_W{1'b0}};
            a_r          <= {W{1'b0}};
            b_r          <= {W{1'b0}};
            fail_a_r     <= {W{1'b0}};
            fail_b_r     <= {W{1'b0}};
            exp_r        <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else if (start) begin
            // A simultaneous handshake or a vector in flight is dropped here.
            state_r    <= ST_WAIT;
            vec_idx_r  <= {CNT_W{1'b0}};
            pass_cnt_r <= {CNT_W{1'b0}};
            fail_cnt_r <= {CNT_W{1'b0}};
            fail_idx_r <= {CNT_W{1'b0}};
            fail_a_r   <= {W{1'b0}};
            fail_b_r   <= {W{1'b0}};
            err_r      <= 1'b0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                ST_WAIT: begin
                    if (vec_valid) begin
                        a_r          <= a;
                        b_r          <= b;
                        exp_r        <= (a == b);
                        settle_cnt_r <= SETTLE_LD;
                        state_r      <= (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == {SET_W{1'b0}}) begin
                        state_r <= ST_CHECK;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (aeqb == exp_r) begin
                        pass_cnt_r <= sat_inc(pass_cnt_r);
                    end else begin
                        fail_cnt_r <= sat_inc(fail_cnt_r);
                        if (!err_r) begin
                            err_r      <= 1'b1;
                            fail_idx_r <= vec_idx_r;
                            fail_a_r   <= a_r;
                            fail_b_r   <= b_r;
                        end
                    end
                    vec_idx_r <= vec_idx_r + 1'b1;
                    if (vec_idx_r == LAST_IDX) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign vec_ready = (state_r == ST_WAIT);
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass_cnt  = pass_cnt_r;
    assign fail_cnt  = fail_cnt_r;
    assign err       = err_r;
    assign fail_idx  = fail_idx_r;
    assign fail_a    = fail_a_r;
    assign fail_b    = fail_b_r;

endmodule
